vga_timing: RTL and testbench
=============================

Name: vga_timing

Overview:
- Source end of the vga_if timing stream that every draw stage (rectangles, snake, board, text overlays) consumes.
- Generates hcount/vcount with matching hsync/vsync/hblnk/vblnk, one pixel per enabled clock.
- Sits at the head of the draw pipeline, directly after the pixel-clock domain entry.
- Also emits a one-cycle frame_start pulse, used by game logic to latch state between frames.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync pulse width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync pulse width (lines)
- V_BP, 23, vertical back porch (lines)
- CNT_W, 11, width of hcount/vcount; must hold H_TOTAL-1 and V_TOTAL-1

Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (628).

Ports:
- clk  input  1  pixel clock
- rst  input  1  asynchronous, active-low reset
- en  input  1  pixel enable; counters advance only when high
- vga_out  vga_if.out  -  timing bundle: hcount/vcount [CNT_W-1:0], hsync, vsync, hblnk, vblnk
- frame_start  output  1  one-cycle pulse when the counters wrap to (0,0)

Behaviour:
- Reset (rst low, asynchronous): hcount=0, vcount=0, hsync=0, vsync=0, hblnk=0, vblnk=0, frame_start=0. These values match the decode of position (0,0).
- All outputs are registered. Sync and blank are decoded from the next-state counter values, so every output field describes the same pixel in the same cycle (zero skew between fields).
- On rising clk with en=1:
  - hcount_next = (hcount==H_TOTAL-1) ? 0 : hcount+1.
  - When hcount wraps: vcount_next = (vcount==V_TOTAL-1) ? 0 : vcount+1. Otherwise vcount holds.
- With en=0: every output holds its value; frame_start is forced to 0.
- Decode, all positive polarity:
  - hblnk = hcount >= H_ACTIVE
  - hsync = H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC
  - vblnk = vcount >= V_ACTIVE
  - vsync = V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC
- frame_start is high for exactly the one enabled cycle in which the outputs show hcount=0, vcount=0 after a wrap from (H_TOTAL-1, V_TOTAL-1). It is not asserted for the reset state.
- After reset release: the first enabled edge gives hcount=1. Line 0 ends after H_TOTAL enabled edges. The first frame_start occurs H_TOTAL*V_TOTAL enabled edges after release.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronous). Counting restarts from (0,0) with no frame_start for the aborted frame.
- Boundary cases:
  - hcount never reaches H_TOTAL; vcount never reaches V_TOTAL.
  - hsync and hblnk overlap; vblnk covers whole lines, including line V_TOTAL-1 up to the wrap.
  - hblnk=1 at hcount=H_TOTAL-1. At the wrap edge, hblnk falls and vcount advances together.
- No combinational path from any input to any output.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined: adds output port frame_cnt [15:0].
  - Reset value 0.
  - Increments on the same edge that asserts frame_start; wraps 16'hFFFF -> 0.
  - Holds when en=0.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then 1056 enabled cycles -> hcount sequence 1..1055,0; vcount steps 0->1 on the wrap edge; hblnk high exactly for hcount 800..1055; hsync high exactly for hcount 840..967.
- Run a full frame -> vblnk high for vcount 600..627; vsync high for vcount 601..604; frame_start pulses once per frame, exactly 663168 enabled cycles apart, with outputs (0,0) in that cycle.
- Toggle en low for 7 cycles at hcount=799 -> all outputs frozen for 7 cycles; the next enabled edge gives hcount=800 with hblnk=1; no frame_start during the stall.
- Assert rst at (hcount=500, vcount=300) between clock edges -> outputs reach all-zero before the next edge; after release, no frame_start until a full frame completes.
- Override parameters to H=4/1/2/1 and V=3/1/1/1 -> H_TOTAL=8, V_TOTAL=6; check wrap, sync and blank positions exhaustively against a reference model.
- With VGA_TIMING_FRAME_CNT_EN defined, run 3 frames -> frame_cnt = 1, 2, 3, each coincident with frame_start; with frame_cnt preloaded via force to 16'hFFFF -> wraps to 0.

Source files
------------

// File: rtl/vga_timing_if.sv
// vga_if: timing bundle shared by every draw stage.
//   hcount/vcount [CNT_W-1:0] : current pixel position
//   hsync/vsync               : positive-polarity sync pulses
//   hblnk/vblnk               : positive-polarity blanking flags
// Modports: out (producer), in (consumer).
interface vga_if #(
    parameter int unsigned CNT_W = 11
);
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;

    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/vga_timing.sv
// vga_timing: head of the draw pipeline. Produces the hcount/vcount raster
// with hsync/vsync/hblnk/vblnk, advancing one pixel per enabled clock, plus
// a one-cycle frame_start pulse on the wrap back to (0,0).
// Ports:
//   clk         : pixel clock
//   rst         : asynchronous active-low reset
//   en          : pixel enable; everything holds while low
//   vga_out     : vga_if.out timing bundle
//   frame_start : one-cycle pulse in the cycle that shows (0,0) after a wrap
//   frame_cnt   : [15:0] frame counter, present only when
//                 VGA_TIMING_FRAME_CNT_EN is defined
// All outputs are registered; sync/blank are decoded from the next-state
// counters so every field of the bundle describes the same pixel.
module vga_timing #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter int unsigned CNT_W    = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    vga_if.out          vga_out,
    output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_BLK_BEG  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_BLK_BEG  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] r_hcount;
    logic [CNT_W-1:0] r_vcount;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_hblnk;
    logic             r_vblnk;
    logic             r_frame_start;

    logic [CNT_W-1:0] w_hcount_nxt;
    logic [CNT_W-1:0] w_vcount_nxt;
    logic             w_h_wrap;
    logic             w_v_wrap;

    // Next raster position; vcount only moves on the line wrap.
    always_comb begin
        w_h_wrap     = (r_hcount == H_LAST);
        w_v_wrap     = (r_vcount == V_LAST);
        w_hcount_nxt = w_h_wrap ? '0 : r_hcount + CNT_W'(1);
        w_vcount_nxt = r_vcount;
        if (w_h_wrap) begin
            w_vcount_nxt = w_v_wrap ? '0 : r_vcount + CNT_W'(1);
        end
    end

    // Counters and decoded flags, all registered from the next-state position.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (en) begin
            r_hcount      <= w_hcount_nxt;
            r_vcount      <= w_vcount_nxt;
            r_hblnk       <= (w_hcount_nxt >= H_BLK_BEG);
            r_hsync       <= (w_hcount_nxt >= H_SYNC_BEG) && (w_hcount_nxt < H_SYNC_END);
            r_vblnk       <= (w_vcount_nxt >= V_BLK_BEG);
            r_vsync       <= (w_vcount_nxt >= V_SYNC_BEG) && (w_vcount_nxt < V_SYNC_END);
            r_frame_start <= w_h_wrap && w_v_wrap;
        end else begin
            r_frame_start <= 1'b0;
        end
    end

    assign vga_out.hcount = r_hcount;
    assign vga_out.vcount = r_vcount;
    assign vga_out.hsync  = r_hsync;
    assign vga_out.vsync  = r_vsync;
    assign vga_out.hblnk  = r_hblnk;
    assign vga_out.vblnk  = r_vblnk;
    assign frame_start    = r_frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Counts completed frames; steps on the same edge that raises frame_start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_cnt <= '0;
        end else if (en && w_h_wrap && w_v_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing.sv
module tb_vga_timing;
    localparam int HT  = 1056;
    localparam int VT  = 628;
    localparam int SHT = 8;
    localparam int SVT = 6;

    typedef struct {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
    } geom_t;

    typedef struct {
        int h; int v;
        bit hs; bit vs; bit hb; bit vb;
        bit fs; int fc; bit en;
    } exp_t;

    geom_t G  = '{800, 40, 128, 88, 600, 1, 4, 23};
    geom_t GS = '{4, 1, 2, 1, 3, 1, 1, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, fs;
    logic rst_s, en_s, fs_s;
    vga_if #(.CNT_W(11)) bus ();
    vga_if #(.CNT_W(3))  bus_s ();
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] fc, fc_s;
`endif

    vga_timing dut (
        .clk(clk), .rst(rst), .en(en), .vga_out(bus), .frame_start(fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc)
`endif
    );

    vga_timing #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .CNT_W(3)
    ) dut_s (
        .clk(clk), .rst(rst_s), .en(en_s), .vga_out(bus_s), .frame_start(fs_s)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc_s)
`endif
    );

    int checks = 0;
    int errors = 0;
    exp_t q[$];
    exp_t qs[$];
    int idx = 0, fcm = 0, idx_s = 0, fcm_s = 0;
    bit wrapped = 0;
    int period_s = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: position is the linear pixel index split by line length,
    // flags come straight from the porch/sync interval boundaries.
    function automatic exp_t model(geom_t g, int i, bit e, bit f, int c);
        exp_t m;
        int ht = g.ha + g.hf + g.hs + g.hb;
        m.h  = i % ht;
        m.v  = i / ht;
        m.hb = (m.h >= g.ha);
        m.hs = (m.h >= g.ha + g.hf) && (m.h < g.ha + g.hf + g.hs);
        m.vb = (m.v >= g.va);
        m.vs = (m.v >= g.va + g.vf) && (m.v < g.va + g.vf + g.vs);
        m.fs = f;
        m.fc = c;
        m.en = e;
        return m;
    endfunction

    task automatic step(input bit e);
        bit f = 0;
        @(negedge clk);
        en = e;
        if (e) begin
            idx = (idx + 1) % (HT * VT);
            f = (idx == 0);
            if (f) begin
                fcm = (fcm + 1) % 65536;
                wrapped = 1;
            end
        end
        q.push_back(model(G, idx, e, f, fcm));
    endtask

    task automatic step_s(input bit e);
        bit f = 0;
        @(negedge clk);
        en_s = e;
        if (e) begin
            idx_s = (idx_s + 1) % (SHT * SVT);
            f = (idx_s == 0);
            if (f) fcm_s = (fcm_s + 1) % 65536;
        end
        qs.push_back(model(GS, idx_s, e, f, fcm_s));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_hcount"}, int'(bus.hcount), 0);
        chk({tag, "_vcount"}, int'(bus.vcount), 0);
        chk({tag, "_hsync"}, int'(bus.hsync), 0);
        chk({tag, "_vsync"}, int'(bus.vsync), 0);
        chk({tag, "_hblnk"}, int'(bus.hblnk), 0);
        chk({tag, "_vblnk"}, int'(bus.vblnk), 0);
        chk({tag, "_frame_start"}, int'(fs), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk({tag, "_frame_cnt"}, int'(fc), 0);
`endif
    endtask

    // Move the raster to (h,v) while stalled, then take one enabled edge so
    // the registered flags are rebuilt from the new position.
    task automatic jump(input int h, input int v, input bit preload);
        @(negedge clk);
        en = 1'b0;
        force dut.r_hcount = 11'(h);
        force dut.r_vcount = 11'(v);
`ifdef VGA_TIMING_FRAME_CNT_EN
        if (preload) begin
            force dut.r_frame_cnt = 16'hFFFF;
            fcm = 16'hFFFF;
        end
`endif
        @(negedge clk);
        release dut.r_hcount;
        release dut.r_vcount;
`ifdef VGA_TIMING_FRAME_CNT_EN
        if (preload) release dut.r_frame_cnt;
`endif
        idx = v * HT + h;
        step(1);
    endtask

    // Monitor for the full-size raster.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("hcount", int'(bus.hcount), x.h);
            chk("vcount", int'(bus.vcount), x.v);
            chk("hsync", int'(bus.hsync), int'(x.hs));
            chk("vsync", int'(bus.vsync), int'(x.vs));
            chk("hblnk", int'(bus.hblnk), int'(x.hb));
            chk("vblnk", int'(bus.vblnk), int'(x.vb));
            chk("frame_start", int'(fs), int'(x.fs));
`ifdef VGA_TIMING_FRAME_CNT_EN
            chk("frame_cnt", int'(fc), x.fc);
`endif
        end
    end

    // Monitor for the reduced raster, including the frame_start period.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (qs.size() > 0) begin
            x = qs.pop_front();
            if (x.en) period_s++;
            chk("s_hcount", int'(bus_s.hcount), x.h);
            chk("s_vcount", int'(bus_s.vcount), x.v);
            chk("s_hsync", int'(bus_s.hsync), int'(x.hs));
            chk("s_vsync", int'(bus_s.vsync), int'(x.vs));
            chk("s_hblnk", int'(bus_s.hblnk), int'(x.hb));
            chk("s_vblnk", int'(bus_s.vblnk), int'(x.vb));
            chk("s_frame_start", int'(fs_s), int'(x.fs));
`ifdef VGA_TIMING_FRAME_CNT_EN
            chk("s_frame_cnt", int'(fc_s), x.fc);
`endif
            if (fs_s) begin
                chk("s_frame_period", period_s, SHT * SVT);
                period_s = 0;
            end
        end
    end

    task automatic small_run();
        rst_s = 1'b1;
        en_s  = 1'b0;
        #2 rst_s = 1'b0;
        repeat (2) @(negedge clk);
        rst_s = 1'b1;
        idx_s = 0;
        fcm_s = 0;
        repeat (400) step_s($urandom_range(0, 3) != 0);
    endtask

    task automatic main_run();
        rst = 1'b1;
        en  = 1'b0;
        #2 rst = 1'b0;
        #1 chk_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idx = 0;
        fcm = 0;
        // Line 0 and its wrap, then random enables.
        repeat (HT) step(1);
        repeat (300) step($urandom_range(0, 3) != 0);
        // Stall at the last visible pixel.
        while (idx % HT != 799) step(1);
        repeat (7) step(0);
        repeat (40) step(1);
        // Vertical blanking region and frame wrap.
        jump(1000, 598, 1'b1);
        for (int n = 0; n < 60000 && !wrapped; n++) step($urandom_range(0, 7) != 0);
        chk("frame_wrap_seen", int'(wrapped), 1);
        repeat (200) step($urandom_range(0, 3) != 0);
        // Asynchronous reset in the middle of a frame.
        jump(490, 300, 1'b0);
        while (idx % HT != 500) step(1);
        @(posedge clk);
        #3;
        en  = 1'b0;
        rst = 1'b0;
        #1 chk_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        idx = 0;
        fcm = 0;
        repeat (2000) step($urandom_range(0, 3) != 0);
    endtask

    initial begin
        fork
            small_run();
            main_run();
        join
        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
